// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and helpers for the multi-cycle MIPS CPU datapath.
//   - CPU phase encoding (S_FETCH/S_EXEC/S_MEM/S_WB), driven by the controller.
//   - Avalon byte-lane enable constants.
//   - op_e: one-hot opcode flags collapsed to a single memory operation, with
//     a fixed priority so illegal multi-flag inputs stay deterministic.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [1:0] S_FETCH = 2'b00;
  localparam logic [1:0] S_EXEC  = 2'b01;
  localparam logic [1:0] S_MEM   = 2'b10;
  localparam logic [1:0] S_WB    = 2'b11;

  localparam logic [3:0] BE_NONE  = 4'b0000;
  localparam logic [3:0] BE_ALL   = 4'b1111;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_HALF0 = 4'b0011;

  typedef enum logic [3:0] {
    OP_NONE, OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_LWL, OP_LWR,
    OP_LUI, OP_SW, OP_SH, OP_SB
  } op_e;

  // Priority order lw > lh > lhu > lb > lbu > lwl > lwr > lui > sw > sh > sb.
  function automatic op_e decode_op(
    input logic lw, input logic lh, input logic lhu, input logic lb,
    input logic lbu, input logic lwl, input logic lwr, input logic lui,
    input logic sw, input logic sh, input logic sb
  );
    if (lw)       return OP_LW;
    else if (lh)  return OP_LH;
    else if (lhu) return OP_LHU;
    else if (lb)  return OP_LB;
    else if (lbu) return OP_LBU;
    else if (lwl) return OP_LWL;
    else if (lwr) return OP_LWR;
    else if (lui) return OP_LUI;
    else if (sw)  return OP_SW;
    else if (sh)  return OP_SH;
    else if (sb)  return OP_SB;
    else          return OP_NONE;
  endfunction

  function automatic logic is_load_op(input op_e op);
    return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_LWL, OP_LWR};
  endfunction

  function automatic logic is_store_op(input op_e op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction

endpackage

// File: rtl/load_store_if.sv
// -----------------------------------------------------------------------------
// load_store_if
// Avalon-MM data/instruction bus, 32-bit data, 32-bit byte address.
//   mem_address     word-aligned byte address
//   mem_readdata    read data returned by memory
//   mem_writedata   write data
//   mem_byteenable  active lanes, little-endian (lane k = bits 8k+7:8k)
//   mem_readenable  read request
//   mem_writeenable write request
//   waitrequest     memory stall; requester holds everything while high
// Modports: master (CPU side), slave (memory side).
// -----------------------------------------------------------------------------
interface load_store_if;
  logic [31:0] mem_address;
  logic [31:0] mem_readdata;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_readenable;
  logic        mem_writeenable;
  logic        waitrequest;

  modport master (
    output mem_address, mem_writedata, mem_byteenable,
           mem_readenable, mem_writeenable,
    input  mem_readdata, waitrequest
  );

  modport slave (
    input  mem_address, mem_writedata, mem_byteenable,
           mem_readenable, mem_writeenable,
    output mem_readdata, waitrequest
  );
endinterface

// File: rtl/ls_load_format.sv
// -----------------------------------------------------------------------------
// ls_load_format
// Combinational write-back formatter for loads and lui.
//   word_i  latched load word          op_i    decoded memory operation
//   lane_i  ea[1:0] (byte lane k)      imm_i   immediate (for lui)
//   data_o  register write data        be_o    register byte lanes to write
// lwl/lwr produce the shifted word plus the lane mask that the register file
// uses to merge with the existing rt value.
// -----------------------------------------------------------------------------
module ls_load_format
  import cpu_pkg::*;
(
  input  logic [31:0] word_i,
  input  op_e         op_i,
  input  logic [1:0]  lane_i,
  input  logic [15:0] imm_i,
  output logic [31:0] data_o,
  output logic [3:0]  be_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    data_o   = 32'h0;
    be_o     = BE_NONE;
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    case (op_i)
      OP_LW:  begin data_o = word_i;                         be_o = BE_ALL; end
      OP_LH:  begin data_o = {{16{half_sel[15]}}, half_sel}; be_o = BE_ALL; end
      OP_LHU: begin data_o = {16'h0, half_sel};              be_o = BE_ALL; end
      OP_LB:  begin data_o = {{24{byte_sel[7]}}, byte_sel};  be_o = BE_ALL; end
      OP_LBU: begin data_o = {24'h0, byte_sel};              be_o = BE_ALL; end
      // ~lane_i equals 3-k for a 2-bit lane index.
      OP_LWL: begin data_o = word_i << {~lane_i, 3'b000};    be_o = BE_ALL << ~lane_i; end
      OP_LWR: begin data_o = word_i >> {lane_i, 3'b000};     be_o = BE_ALL >> lane_i; end
      OP_LUI: begin data_o = {imm_i, 16'h0000};              be_o = BE_ALL; end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store.sv
// -----------------------------------------------------------------------------
// load_store
// Load/store and instruction-fetch memory unit of the multi-cycle MIPS CPU.
// Drives the Avalon bus according to the CPU phase `state`, latches fetched
// instructions and load data, and formats load results for write-back.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   state               CPU phase: 00 FETCH, 01 EXEC, 10 MEM, 11 WB
//   lb..sb              decoded opcode flags (at most one high)
//   offset, rs_data     immediate and base; ea = rs_data + sext(offset)
//   rt_data, rt         store data / lwl-lwr merge base, destination index
//   reg_*               register file write port
//   instruction_out     latched fetched instruction
//   PC_in               fetch address
//   addr_error          misaligned access in MEM (only with LS_ALIGN_CHECK_EN)
//   bus                 Avalon master (load_store_if.master)
//
// Build option: define LS_ALIGN_CHECK_EN to flag and suppress misaligned
// lh/lhu/sh/lw/sw accesses; otherwise low address bits are ignored.
// -----------------------------------------------------------------------------
module load_store
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        state,
  input  logic              lb,
  input  logic              lbu,
  input  logic              lh,
  input  logic              lhu,
  input  logic              lui,
  input  logic              lw,
  input  logic              lwl,
  input  logic              lwr,
  input  logic              sb,
  input  logic              sh,
  input  logic              sw,
  input  logic [15:0]       offset,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  input  logic [4:0]        rt,
  output logic [3:0]        reg_byteenable,
  output logic              reg_writeenable,
  output logic [31:0]       reg_writedata,
  output logic [31:0]       instruction_out,
  input  logic [31:0]       PC_in,
`ifdef LS_ALIGN_CHECK_EN
  output logic              addr_error,
`endif
  load_store_if.master      bus
);

  op_e         op;
  logic [31:0] ea;
  logic        ld_op;
  logic        st_op;
  logic        addr_err_c;   // misaligned access in MEM (0 without the check)
  logic        wb_block;     // suppress write-back after a flagged access

  logic [31:0] instr_q, instr_d;
  logic [31:0] load_q, load_d;

  logic [31:0] fmt_data;
  logic [3:0]  fmt_be;

  assign op    = decode_op(lw, lh, lhu, lb, lbu, lwl, lwr, lui, sw, sh, sb);
  assign ea    = rs_data + {{16{offset[15]}}, offset};
  assign ld_op = is_load_op(op);
  assign st_op = is_store_op(op);

`ifdef LS_ALIGN_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    addr_err_c = 1'b0;
    if (state == S_MEM) begin
      if (op inside {OP_LH, OP_LHU, OP_SH}) addr_err_c = ea[0];
      if (op inside {OP_LW, OP_SW})         addr_err_c = (ea[1:0] != 2'b00);
    end
  end

  // Sticky across MEM -> WB; any other phase clears it.
  always_comb begin
    case (state)
      S_MEM:   err_d = err_q | addr_err_c;
      S_WB:    err_d = err_q;
      default: err_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign addr_error = addr_err_c;
  assign wb_block   = err_q;
`else
  assign addr_err_c = 1'b0;
  assign wb_block   = 1'b0;
`endif

  // Bus drive. Outputs are pure functions of the held inputs, so they stay
  // stable for as long as the controller holds `state` under waitrequest.
  always_comb begin
    bus.mem_address     = {ea[31:2], 2'b00};
    bus.mem_writedata   = 32'h0;
    bus.mem_byteenable  = BE_NONE;
    bus.mem_readenable  = 1'b0;
    bus.mem_writeenable = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_address    = PC_in;
        bus.mem_readenable = 1'b1;
        bus.mem_byteenable = BE_ALL;
      end
      S_MEM: begin
        if (ld_op) begin
          bus.mem_readenable = ~addr_err_c;
          bus.mem_byteenable = BE_ALL;
        end else if (st_op) begin
          bus.mem_writeenable = ~addr_err_c;
          case (op)
            OP_SB: begin
              bus.mem_byteenable = BE_BYTE0 << ea[1:0];
              bus.mem_writedata  = {4{rt_data[7:0]}};
            end
            OP_SH: begin
              bus.mem_byteenable = BE_HALF0 << {ea[1], 1'b0};
              bus.mem_writedata  = {2{rt_data[15:0]}};
            end
            default: begin
              bus.mem_byteenable = BE_ALL;
              bus.mem_writedata  = rt_data;
            end
          endcase
        end
      end
      default: ;
    endcase
    // Reset gates the strobes combinationally so they drop without a clock.
    if (reset) begin
      bus.mem_readenable  = 1'b0;
      bus.mem_writeenable = 1'b0;
      bus.mem_byteenable  = BE_NONE;
    end
  end

  always_comb begin
    instr_d = instr_q;
    load_d  = load_q;
    if (!bus.waitrequest) begin
      if (state == S_FETCH)                         instr_d = bus.mem_readdata;
      if (state == S_MEM && ld_op && !addr_err_c)   load_d  = bus.mem_readdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (reset) begin
      instr_q <= 32'h0;
      load_q  <= 32'h0;
    end else begin
      instr_q <= instr_d;
      load_q  <= load_d;
    end
  end

  ls_load_format u_fmt (
    .word_i (load_q),
    .op_i   (op),
    .lane_i (ea[1:0]),
    .imm_i  (offset),
    .data_o (fmt_data),
    .be_o   (fmt_be)
  );

  assign instruction_out = instr_q;
  assign reg_writedata   = fmt_data;
  assign reg_byteenable  = (state == S_WB && !reset) ? fmt_be : BE_NONE;
  assign reg_writeenable = (state == S_WB) && !reset && !wb_block &&
                           (ld_op || op == OP_LUI) && (rt != 5'd0);

endmodule

// File: tb/tb_load_store.sv
// -----------------------------------------------------------------------------
// tb_load_store
// Self-checking bench for load_store: directed scenarios plus a randomized
// MEM/WB sweep compared against a behavioural model of the load/store rules.
// -----------------------------------------------------------------------------
module tb_load_store;

  // Operation codes local to the bench.
  localparam int F_NONE = -1, F_LW = 0, F_LH = 1, F_LHU = 2, F_LB = 3, F_LBU = 4,
                 F_LWL = 5, F_LWR = 6, F_LUI = 7, F_SW = 8, F_SH = 9, F_SB = 10;

`ifdef LS_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
  logic addr_error;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  state;
  logic        lb, lbu, lh, lhu, lui, lw, lwl, lwr, sb, sh, sw;
  logic [15:0] offset;
  logic [31:0] rs_data, rt_data, PC_in;
  logic [4:0]  rt;
  logic [3:0]  reg_byteenable;
  logic        reg_writeenable;
  logic [31:0] reg_writedata, instruction_out;

  int total = 0;
  int bad   = 0;

  load_store_if bus ();

  load_store dut (
    .clk (clk), .reset (reset), .state (state),
    .lb (lb), .lbu (lbu), .lh (lh), .lhu (lhu), .lui (lui), .lw (lw),
    .lwl (lwl), .lwr (lwr), .sb (sb), .sh (sh), .sw (sw),
    .offset (offset), .rs_data (rs_data), .rt_data (rt_data), .rt (rt),
    .reg_byteenable (reg_byteenable), .reg_writeenable (reg_writeenable),
    .reg_writedata (reg_writedata), .instruction_out (instruction_out),
    .PC_in (PC_in),
`ifdef LS_ALIGN_CHECK_EN
    .addr_error (addr_error),
`endif
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int f);
    {lb, lbu, lh, lhu, lui, lw, lwl, lwr, sb, sh, sw} = '0;
    case (f)
      F_LW: lw = 1;   F_LH: lh = 1;   F_LHU: lhu = 1; F_LB: lb = 1;
      F_LBU: lbu = 1; F_LWL: lwl = 1; F_LWR: lwr = 1; F_LUI: lui = 1;
      F_SW: sw = 1;   F_SH: sh = 1;   F_SB: sb = 1;
      default: ;
    endcase
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_is_load(input int f);
    return f >= F_LW && f <= F_LWR;
  endfunction

  function automatic bit m_misaligned(input int f, input logic [31:0] ea);
    if (!ALIGN_ON) return 0;
    if (f == F_LH || f == F_LHU || f == F_SH) return ea % 2 != 0;
    if (f == F_LW || f == F_SW) return ea % 4 != 0;
    return 0;
  endfunction

  function automatic logic [31:0] m_wdata(input int f, input logic [31:0] w,
                                          input int k, input logic [15:0] imm);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((w / (32'd1 << (8 * k))) % 256);
    h = (k >= 2) ? w[31:16] : w[15:0];
    case (f)
      F_LW:  return w;
      F_LH:  return 32'(signed'(h));
      F_LHU: return {16'h0, h};
      F_LB:  return 32'(signed'(b));
      F_LBU: return {24'h0, b};
      F_LWL: return w << (8 * (3 - k));
      F_LWR: return w >> (8 * k);
      F_LUI: return {imm, 16'h0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] m_rbe(input int f, input int k);
    logic [3:0] be;
    be = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (f == F_LWL)      be[i] = (i >= 3 - k);
      else if (f == F_LWR) be[i] = (i < 4 - k);
      else                 be[i] = 1'b1;
    end
    return be;
  endfunction

  function automatic logic [3:0] m_sbe(input int f, input int k);
    logic [3:0] be;
    be = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (f == F_SB)      be[i] = (i == k);
      else if (f == F_SH) be[i] = (i / 2 == k / 2);
      else                be[i] = 1'b1;
    end
    return be;
  endfunction

  function automatic logic [31:0] m_swdata(input int f, input logic [31:0] d);
    if (f == F_SB) return {4{d[7:0]}};
    if (f == F_SH) return {2{d[15:0]}};
    return d;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    total++; if (instruction_out !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", instruction_out); end
    total++; if ({bus.mem_readenable, bus.mem_writeenable, bus.mem_byteenable} !== 6'b0) begin
      bad++; $display("FAIL reset_bus got=%b%b%b want=000000", bus.mem_readenable, bus.mem_writeenable, bus.mem_byteenable); end
    total++; if (reg_writeenable !== 1'b0) begin bad++; $display("FAIL reset_regwe got=%b want=0", reg_writeenable); end
  endtask

  task automatic test_fetch();
    tick();
    state = 2'b00; set_op(F_NONE); PC_in = 32'hBFC00000;
    bus.mem_readdata = 32'h8C220004; bus.waitrequest = 1'b1;
    #1;
    total++; if (bus.mem_address !== 32'hBFC00000 || bus.mem_readenable !== 1'b1 || bus.mem_byteenable !== 4'b1111) begin
      bad++; $display("FAIL fetch_bus got=%h/%b/%b want=bfc00000/1/1111", bus.mem_address, bus.mem_readenable, bus.mem_byteenable); end
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      total++; if (bus.mem_address !== 32'hBFC00000 || instruction_out !== 32'h0) begin
        bad++; $display("FAIL fetch_stall%0d got addr=%h instr=%h want=bfc00000/0", c, bus.mem_address, instruction_out); end
    end
    bus.waitrequest = 1'b0;
    tick(); #1;
    total++; if (instruction_out !== 32'h8C220004) begin bad++; $display("FAIL fetch_latch got=%h want=8c220004", instruction_out); end
  endtask

  task automatic test_lb_lbu();
    tick();
    state = 2'b10; set_op(F_LB); rs_data = 32'h1000; offset = 16'h0003; rt = 5'd2;
    bus.mem_readdata = 32'h80FF1234; bus.waitrequest = 1'b0;
    #1;
    total++; if (bus.mem_address !== 32'h1000 || bus.mem_readenable !== 1'b1) begin
      bad++; $display("FAIL lb_addr got=%h/%b want=1000/1", bus.mem_address, bus.mem_readenable); end
    tick(); state = 2'b11; #1;
    total++; if (reg_writedata !== 32'hFFFFFF80 || reg_byteenable !== 4'b1111 || reg_writeenable !== 1'b1) begin
      bad++; $display("FAIL lb_wb got=%h/%b/%b want=ffffff80/1111/1", reg_writedata, reg_byteenable, reg_writeenable); end
    set_op(F_LBU); #1;
    total++; if (reg_writedata !== 32'h00000080) begin bad++; $display("FAIL lbu_wb got=%h want=00000080", reg_writedata); end
  endtask

  task automatic test_lwl_lwr();
    tick();
    state = 2'b10; set_op(F_LWL); rs_data = 32'h2001; offset = 16'h0; rt = 5'd3;
    bus.mem_readdata = 32'hAABBCCDD;
    tick(); state = 2'b11; #1;
    total++; if (reg_writedata !== 32'hCCDD0000 || reg_byteenable !== 4'b1100) begin
      bad++; $display("FAIL lwl_wb got=%h/%b want=ccdd0000/1100", reg_writedata, reg_byteenable); end
    set_op(F_LWR); #1;
    total++; if (reg_writedata !== 32'h00AABBCC || reg_byteenable !== 4'b0111) begin
      bad++; $display("FAIL lwr_wb got=%h/%b want=00aabbcc/0111", reg_writedata, reg_byteenable); end
  endtask

  task automatic test_stores();
    tick();
    state = 2'b10; set_op(F_SH); rs_data = 32'h3000; offset = 16'h0002; rt_data = 32'h1234BEEF;
    #1;
    total++; if (bus.mem_byteenable !== 4'b1100 || bus.mem_writedata !== 32'hBEEFBEEF || bus.mem_writeenable !== 1'b1 || bus.mem_address !== 32'h3000) begin
      bad++; $display("FAIL sh_bus got=%b/%h/%b/%h want=1100/beefbeef/1/3000", bus.mem_byteenable, bus.mem_writedata, bus.mem_writeenable, bus.mem_address); end
    set_op(F_SB); offset = 16'h0001; #1;
    total++; if (bus.mem_byteenable !== 4'b0010 || bus.mem_writedata !== 32'hEFEFEFEF) begin
      bad++; $display("FAIL sb_bus got=%b/%h want=0010/efefefef", bus.mem_byteenable, bus.mem_writedata); end
  endtask

  task automatic test_lui();
    tick();
    state = 2'b10; set_op(F_LUI); offset = 16'hABCD; rt = 5'd5; #1;
    total++; if (bus.mem_readenable !== 1'b0 || bus.mem_writeenable !== 1'b0 || bus.mem_byteenable !== 4'b0000) begin
      bad++; $display("FAIL lui_mem got=%b/%b/%b want=0/0/0000", bus.mem_readenable, bus.mem_writeenable, bus.mem_byteenable); end
    tick(); state = 2'b11; #1;
    total++; if (reg_writedata !== 32'hABCD0000 || reg_writeenable !== 1'b1) begin
      bad++; $display("FAIL lui_wb got=%h/%b want=abcd0000/1", reg_writedata, reg_writeenable); end
    rt = 5'd0; #1;
    total++; if (reg_writeenable !== 1'b0) begin bad++; $display("FAIL lui_rt0 got=%b want=0", reg_writeenable); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int          f, k, stalls;
      logic [31:0] ea, word;
      bit          mis;
      tick();
      state = 2'b01; set_op(F_NONE); #1;
      total++; if (bus.mem_readenable !== 1'b0 || bus.mem_writeenable !== 1'b0) begin
        bad++; $display("FAIL rnd_exec it=%0d got=%b/%b want=0/0", it, bus.mem_readenable, bus.mem_writeenable); end
      f       = int'($urandom_range(0, 10));
      rs_data = $urandom; offset = 16'($urandom); rt_data = $urandom;
      rt      = 5'($urandom_range(0, 31)); word = $urandom;
      ea      = rs_data + 32'(signed'(offset));
      k       = int'(ea % 4);
      mis     = m_misaligned(f, ea);
      stalls  = int'($urandom_range(0, 2));
      tick();
      state = 2'b10; set_op(f);
      for (int s = 0; s <= stalls; s++) begin
        bus.waitrequest  = (s < stalls);
        bus.mem_readdata = (s < stalls) ? $urandom : word;
        #1;
        total++;
        if (m_is_load(f)) begin
          if (bus.mem_address !== (ea & ~32'd3) || bus.mem_readenable !== !mis || bus.mem_writeenable !== 1'b0 || bus.mem_byteenable !== 4'b1111) begin
            bad++; $display("FAIL rnd_ld_mem it=%0d f=%0d got=%h/%b/%b want=%h/%b/1111", it, f, bus.mem_address, bus.mem_readenable, bus.mem_byteenable, ea & ~32'd3, !mis); end
        end else if (f >= F_SW) begin
          if (bus.mem_address !== (ea & ~32'd3) || bus.mem_writeenable !== !mis || bus.mem_readenable !== 1'b0 ||
              bus.mem_byteenable !== m_sbe(f, k) || bus.mem_writedata !== m_swdata(f, rt_data)) begin
            bad++; $display("FAIL rnd_st_mem it=%0d f=%0d got=%h/%b/%b/%h want=%h/%b/%b/%h", it, f, bus.mem_address, bus.mem_writeenable,
                            bus.mem_byteenable, bus.mem_writedata, ea & ~32'd3, !mis, m_sbe(f, k), m_swdata(f, rt_data)); end
        end else begin
          if (bus.mem_readenable !== 1'b0 || bus.mem_writeenable !== 1'b0) begin
            bad++; $display("FAIL rnd_lui_mem it=%0d got=%b/%b want=0/0", it, bus.mem_readenable, bus.mem_writeenable); end
        end
        if (s < stalls) tick();
      end
      tick();
      state = 2'b11; bus.waitrequest = 1'b0; bus.mem_readdata = $urandom; #1;
      total++;
      if (reg_writeenable !== ((m_is_load(f) || f == F_LUI) && rt != 0 && !mis)) begin
        bad++; $display("FAIL rnd_wb_we it=%0d f=%0d got=%b", it, f, reg_writeenable);
      end else if ((m_is_load(f) || f == F_LUI) && !mis &&
                   (reg_writedata !== m_wdata(f, word, k, offset) || reg_byteenable !== m_rbe(f, k))) begin
        bad++; $display("FAIL rnd_wb_data it=%0d f=%0d k=%0d got=%h/%b want=%h/%b", it, f, k, reg_writedata, reg_byteenable,
                        m_wdata(f, word, k, offset), m_rbe(f, k));
      end
    end
  endtask

  task automatic test_reset_mid_access();
    tick();
    state = 2'b10; set_op(F_LW); rs_data = 32'h5000; offset = 16'h0; bus.waitrequest = 1'b1; #1;
    total++; if (bus.mem_readenable !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b want=1", bus.mem_readenable); end
    reset = 1'b1; #1;
    total++; if (bus.mem_readenable !== 1'b0 || bus.mem_byteenable !== 4'b0000 || instruction_out !== 32'h0) begin
      bad++; $display("FAIL rst_mid got=%b/%b/%h want=0/0000/0", bus.mem_readenable, bus.mem_byteenable, instruction_out); end
    tick(); reset = 1'b0; bus.waitrequest = 1'b0;
  endtask

`ifdef LS_ALIGN_CHECK_EN
  task automatic test_align();
    tick();
    state = 2'b10; set_op(F_LW); rs_data = 32'h4000; offset = 16'h0002; rt = 5'd7; #1;
    total++; if (addr_error !== 1'b1 || bus.mem_readenable !== 1'b0) begin
      bad++; $display("FAIL align_mem got=%b/%b want=1/0", addr_error, bus.mem_readenable); end
    tick(); state = 2'b11; #1;
    total++; if (reg_writeenable !== 1'b0) begin bad++; $display("FAIL align_wb got=%b want=0", reg_writeenable); end
  endtask
`endif

  initial begin
    reset = 1'b1; state = 2'b00; set_op(F_NONE);
    offset = '0; rs_data = '0; rt_data = '0; rt = '0; PC_in = '0;
    bus.mem_readdata = '0; bus.waitrequest = 1'b0;
    #3;
    test_reset();
    tick(); reset = 1'b0;
    test_fetch();
    test_lb_lbu();
    test_lwl_lwr();
    test_stores();
    test_lui();
    test_random();
    test_reset_mid_access();
`ifdef LS_ALIGN_CHECK_EN
    test_align();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store.md
Name: load_store

Overview:
- Load/store and instruction-fetch memory unit of the multi-cycle MIPS CPU.
- Drives the Avalon-MM data/instruction bus according to the CPU phase input `state`.
- Latches fetched instructions and load data, then formats load results for register write-back.
- Sits between the control/decode stage, the register file and the external Avalon memory.

Parameters:
- None. The bus is fixed at 32-bit data and 32-bit byte address.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- state  in  2  CPU phase: 00 FETCH, 01 EXEC, 10 MEM, 11 WB
- lb, lbu, lh, lhu, lui, lw, lwl, lwr, sb, sh, sw  in  1 each  decoded opcode flags, at most one high
- offset  in  16  immediate field
- rs_data  in  32  base register value
- rt_data  in  32  rt register value (store data; merge base for lwl/lwr)
- rt  in  5  destination register index
- reg_byteenable  out  4  byte lanes of rt to write
- reg_writeenable  out  1  register write strobe
- reg_writedata  out  32  formatted load result
- instruction_out  out  32  latched fetched instruction
- PC_in  in  32  fetch address
- mem_readdata  in  32  Avalon read data
- mem_byteenable  out  4  Avalon byte enables
- mem_writedata  out  32  Avalon write data
- mem_address  out  32  Avalon byte address, always word-aligned ({addr[31:2],2'b00})
- waitrequest  in  1  Avalon stall
- mem_writeenable  out  1  Avalon write
- mem_readenable  out  1  Avalon read

Behaviour:
- Effective address: ea = rs_data + sign_extend(offset), combinational.
- Byte-lane convention: little-endian; ea[1:0]=k selects bits 8k+7:8k.
- Reset: instruction_out and the load-data register clear to 0. While reset is high, all enables are 0 and mem_byteenable is 0.
- FETCH:
  - mem_address=PC_in, mem_readenable=1, mem_byteenable=1111.
  - On a rising edge with waitrequest=0, instruction_out <= mem_readdata.
  - instruction_out holds at all other times.
- EXEC:
  - No bus activity; all enables 0.
- MEM, loads (lb/lbu/lh/lhu/lw/lwl/lwr):
  - mem_readenable=1, byteenable=1111, address=aligned ea.
  - Load register <= mem_readdata on an edge with waitrequest=0.
- MEM, stores:
  - mem_writeenable=1.
  - sb: byteenable=1<<k, writedata=rt_data[7:0] replicated in all lanes.
  - sh: byteenable=0011<<(2*ea[1]), writedata=rt_data[15:0] replicated.
  - sw: byteenable=1111, writedata=rt_data.
- MEM, lui or no flag: no bus activity.
- waitrequest=1: address, data, byteenable and enables stay stable. Nothing is latched. The external controller holds `state`.
- WB (reg_writeenable=1 only for a load or lui with rt≠0):
  - lb/lbu: byte k, sign-/zero-extended; reg_byteenable=1111.
  - lh/lhu: half ea[1], sign-/zero-extended; reg_byteenable=1111.
  - lw: full word; reg_byteenable=1111.
  - lwl: writedata = word << 8*(3-k); reg_byteenable = upper k+1 lanes (e.g. k=1 → 1100).
  - lwr: writedata = word >> 8*k; reg_byteenable = lower 4-k lanes (e.g. k=1 → 0111).
  - lui: writedata={offset,16'h0000}; reg_byteenable=1111.
- Outside WB: reg_writeenable=0, reg_byteenable=0000.
- Misaligned lh/lhu/sh/lw/sw (feature off): low address bits are ignored, i.e. the access is forced to alignment.
- Multiple flags high: undefined input. The fixed priority lw>lh>lhu>lb>lbu>lwl>lwr>lui>sw>sh>sb keeps the behaviour deterministic.
- Reset asserted mid-access: enables drop immediately (asynchronous); registers clear.

Optional Feature:
- LS_ALIGN_CHECK_EN defined:
  - Adds output addr_error (1 bit), high combinationally in MEM for a misaligned lh/lhu/sh (ea[0]=1) or lw/sw (ea[1:0]≠0).
  - When high: mem_readenable and mem_writeenable are 0, and reg_writeenable in the following WB is 0. A sticky flag is set on the MEM edge and cleared when leaving WB.
- LS_ALIGN_CHECK_EN undefined: the port is absent and misaligned accesses are forced to alignment.

Decomposition:
- Shared package cpu_pkg: state encoding constants (S_FETCH, S_EXEC, S_MEM, S_WB) and the byte-lane enable constants.
- One natural sub-module: ls_load_format, combinational word + opcode + ea[1:0] → reg_writedata, reg_byteenable.
- Store lane steering stays inline.

Test Plan:
- Fetch: state=00, PC_in=0xBFC00000, mem_readdata=0x8C220004, waitrequest=1 for 2 cycles then 0 → mem_address=0xBFC00000 throughout; instruction_out=0x8C220004 only after the unstalled edge.
- lb sign extension: rs_data=0x1000, offset=0x0003, word=0x80FF1234 → mem_address=0x1000, reg_writedata=0xFFFFFF80, reg_byteenable=1111. lbu with the same inputs → 0x00000080.
- lwl/lwr: rs_data=0x2001, offset=0, word=0xAABBCCDD → lwl: writedata=0xCCDD0000, byteenable=1100; lwr: writedata=0x00AABBCC, byteenable=0111.
- sh/sb: sh at ea=0x3002, rt_data=0x1234BEEF → byteenable=1100, writedata=0xBEEFBEEF, mem_writeenable=1. sb at ea=0x3001 → byteenable=0010.
- lui offset=0xABCD, rt=5, state=11 → reg_writedata=0xABCD0000, reg_writeenable=1, no bus access in MEM. With rt=0 → reg_writeenable=0.
- Reset pulse during MEM with a load active → enables 0 immediately; instruction_out=0; with LS_ALIGN_CHECK_EN, lw at ea=0x4002 → addr_error=1 and no read issued.
